// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
//   Shared definitions for the RV32I load/store controller:
//     - funct3 encodings for the access sizes (F3_B/H/W/BU/HU)
//     - controller state encoding
//     - byte-enable generation and store-data lane replication
//     - funct3 legality and misalignment helpers
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    RESP     = 2'd3
  } state_t;

  // Halfword enables use only a[1]: an odd halfword address is pulled down to
  // the aligned half when misalignment is not trapped.
  function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] a);
    case (funct3)
      F3_B, F3_BU: be_gen = 4'b0001 << a;
      F3_H, F3_HU: be_gen = 4'b0011 << {a[1], 1'b0};
      default:     be_gen = 4'b1111;
    endcase
  endfunction

  // Replicate the right-justified store data across every lane so the memory
  // only has to honour the byte enables.
  function automatic logic [31:0] wdata_rep(input logic [2:0] funct3, input logic [31:0] d);
    case (funct3)
      F3_B:    wdata_rep = {4{d[7:0]}};
      F3_H:    wdata_rep = {2{d[15:0]}};
      default: wdata_rep = d;
    endcase
  endfunction

  // Loads reject 011/110/111; stores accept only SB/SH/SW.
  function automatic logic f3_legal(input logic wr, input logic [2:0] funct3);
    if (wr) f3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    else    f3_legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] funct3, input logic [1:0] a);
    case (funct3)
      F3_H, F3_HU: f3_misaligned = a[0];
      F3_W:        f3_misaligned = |a;
      default:     f3_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_lane_extract.sv
// -----------------------------------------------------------------------------
// load_lane_extract
//   Combinational lane select plus sign/zero extension of a raw read word.
//   Ports:
//     RawWord  in  32  word returned by the data memory
//     ByteOff  in  2   low address bits of the access
//     Funct3   in  3   RV32I load funct3
//     ExtData  out 32  extended load result
// -----------------------------------------------------------------------------
module load_lane_extract
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] RawWord,
  input  logic [1:0]  ByteOff,
  input  logic [2:0]  Funct3,
  output logic [31:0] ExtData
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = RawWord[{ByteOff, 3'b000} +: 8];
  // Only a[1] selects the half; a[0] is ignored (forced-aligned halfword).
  assign w_half = ByteOff[1] ? RawWord[31:16] : RawWord[15:0];

  always_comb begin
    case (Funct3)
      F3_B:    ExtData = {{24{w_byte[7]}}, w_byte};
      F3_BU:   ExtData = {24'h0, w_byte};
      F3_H:    ExtData = {{16{w_half[15]}}, w_half};
      F3_HU:   ExtData = {16'h0, w_half};
      default: ExtData = RawWord;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//   Sequences one RV32I load/store at a time between EX/MEM and the data memory.
//   IDLE -> MEM_REQ -> (load) MEM_WAIT -> RESP -> IDLE; stores post from MEM_REQ.
//   Illegal funct3 (and, when trapping, misaligned accesses) skip the memory and
//   respond with an error. A timeout aborts MEM_REQ/MEM_WAIT with a bus error.
//
//   Optional feature: MEM_MISALIGN_TRAP_EN
//     defined   - misaligned half/word accesses are not issued; RESP carries
//                 RspErr=1 and MisalignTrap=1 (extra output port).
//     undefined - unaligned low bits are ignored and the access proceeds.
//
//   Parameters:
//     TIMEOUT_CYCLES  cycles allowed in MEM_REQ+MEM_WAIT (0 disables)
//     CNT_W           timeout counter width, 2**CNT_W > TIMEOUT_CYCLES
//   Ports:
//     clk, reset                          clock, synchronous active-high reset
//     ReqValid/ReqReady/ReqWrite/ReqFunct3/ReqAddr/ReqWData   pipeline request
//     RspValid/RspData/RspErr             one-cycle completion
//     Busy                                controller not idle
//     MemReqValid/MemReqReady/MemWe/MemBe/MemAddr/MemWData    memory request
//     MemRspValid/MemRData/MemRspErr      memory read response
//     MisalignTrap                        misalignment flag (trap build only)
// -----------------------------------------------------------------------------
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [2:0]  ReqFunct3,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        RspValid,
  output logic [31:0] RspData,
  output logic        RspErr,
  output logic        Busy,
  output logic        MemReqValid,
  input  logic        MemReqReady,
  output logic        MemWe,
  output logic [3:0]  MemBe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic        MemRspValid,
  input  logic [31:0] MemRData,
  input  logic        MemRspErr
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        MisalignTrap
`endif
);

  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_write;
  logic [2:0]       r_f3;
  logic [1:0]       r_off;

  logic             w_legal;
  logic             w_mis;
  logic             w_expire;
  logic [31:0]      w_ext;

  assign w_legal = f3_legal(ReqWrite, ReqFunct3);

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_mis = w_legal && f3_misaligned(ReqFunct3, ReqAddr[1:0]);
`else
  assign w_mis = 1'b0;
`endif

  // Counter value r_cnt is the number of cycles already spent; expiry fires in
  // the TIMEOUT_CYCLES-th cycle so RESP follows exactly TIMEOUT_CYCLES cycles.
  assign w_expire = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

  load_lane_extract u_lane (
    .RawWord (MemRData),
    .ByteOff (r_off),
    .Funct3  (r_f3),
    .ExtData (w_ext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_f3        <= '0;
      r_off       <= '0;
      ReqReady    <= 1'b1;
      Busy        <= 1'b0;
      RspValid    <= 1'b0;
      RspData     <= '0;
      RspErr      <= 1'b0;
      MemReqValid <= 1'b0;
      MemWe       <= 1'b0;
      MemBe       <= '0;
      MemAddr     <= '0;
      MemWData    <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      MisalignTrap <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          // ReqReady is high throughout IDLE, so ReqValid alone is the accept.
          if (ReqValid) begin
            r_write  <= ReqWrite;
            r_f3     <= ReqFunct3;
            r_off    <= ReqAddr[1:0];
            ReqReady <= 1'b0;
            Busy     <= 1'b1;
            if (!w_legal || w_mis) begin
              r_state  <= RESP;
              RspValid <= 1'b1;
              RspErr   <= 1'b1;
              RspData  <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
              MisalignTrap <= w_mis;
`endif
            end else begin
              r_state     <= MEM_REQ;
              r_cnt       <= '0;
              MemReqValid <= 1'b1;
              MemWe       <= ReqWrite;
              MemBe       <= be_gen(ReqFunct3, ReqAddr[1:0]);
              MemAddr     <= {ReqAddr[31:2], 2'b00};
              MemWData    <= wdata_rep(ReqFunct3, ReqWData);
            end
          end
        end

        MEM_REQ: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // Handshake is tested first so it wins over a coincident expiry.
          if (MemReqReady || w_expire) begin
            MemReqValid <= 1'b0;
            MemWe       <= 1'b0;
            MemBe       <= '0;
            MemAddr     <= '0;
            MemWData    <= '0;
          end
          if (MemReqReady) begin
            if (r_write) begin
              r_state  <= RESP;
              RspValid <= 1'b1;
              RspErr   <= 1'b0;
              RspData  <= '0;
            end else begin
              r_state <= MEM_WAIT;
            end
          end else if (w_expire) begin
            r_state  <= RESP;
            RspValid <= 1'b1;
            RspErr   <= 1'b1;
            RspData  <= '0;
          end
        end

        MEM_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (MemRspValid) begin
            r_state  <= RESP;
            RspValid <= 1'b1;
            RspErr   <= MemRspErr;
            RspData  <= MemRspErr ? '0 : w_ext;
          end else if (w_expire) begin
            r_state  <= RESP;
            RspValid <= 1'b1;
            RspErr   <= 1'b1;
            RspData  <= '0;
          end
        end

        RESP: begin
          r_state  <= IDLE;
          RspValid <= 1'b0;
          RspErr   <= 1'b0;
          RspData  <= '0;
          ReqReady <= 1'b1;
          Busy     <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
          MisalignTrap <= 1'b0;
`endif
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//   Directed and randomized bench for mem_access_ctrl built with a short
//   timeout (8 cycles). Expected values come from an arithmetic model of the
//   access rules (size, alignment, extension), not from the RTL structure.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ReqValid, ReqReady, ReqWrite;
  logic [2:0]  ReqFunct3;
  logic [31:0] ReqAddr, ReqWData;
  logic        RspValid, RspErr, Busy;
  logic [31:0] RspData;
  logic        MemReqValid, MemReqReady, MemWe;
  logic [3:0]  MemBe;
  logic [31:0] MemAddr, MemWData;
  logic        MemRspValid, MemRspErr;
  logic [31:0] MemRData;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        MisalignTrap;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .ReqValid    (ReqValid),
    .ReqReady    (ReqReady),
    .ReqWrite    (ReqWrite),
    .ReqFunct3   (ReqFunct3),
    .ReqAddr     (ReqAddr),
    .ReqWData    (ReqWData),
    .RspValid    (RspValid),
    .RspData     (RspData),
    .RspErr      (RspErr),
    .Busy        (Busy),
    .MemReqValid (MemReqValid),
    .MemReqReady (MemReqReady),
    .MemWe       (MemWe),
    .MemBe       (MemBe),
    .MemAddr     (MemAddr),
    .MemWData    (MemWData),
    .MemRspValid (MemRspValid),
    .MemRData    (MemRData),
    .MemRspErr   (MemRspErr)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .MisalignTrap(MisalignTrap)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int sz(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit legal(input bit wr, input logic [2:0] f3);
    if (wr) return f3 inside {3'd0, 3'd1, 3'd2};
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  // Offset of the access once alignment is forced down to its natural size.
  function automatic int aoff(input logic [2:0] f3, input logic [31:0] addr);
    int a;
    a = int'(addr[1:0]);
    return a - (a % sz(f3));
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] raw);
    int s;
    longint v;
    s = sz(f3);
    v = (longint'(raw) >> (8 * aoff(f3, addr))) % (64'sd1 << (8 * s));
    if (!f3[2] && s < 4 && v >= (64'sd1 << (8 * s - 1))) v = v - (64'sd1 << (8 * s));
    return v[31:0];
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] addr);
    int v;
    v = ((1 << sz(f3)) - 1) << aoff(f3, addr);
    return v[3:0];
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] d);
    int s;
    longint m, r;
    s = sz(f3);
    m = longint'(d) % (64'sd1 << (8 * s));
    r = 0;
    for (int i = 0; i < 4 / s; i++) r = r | (m << (8 * s * i));
    return r[31:0];
  endfunction

  // One full transaction: rdy_dly idle cycles before MemReqReady,
  // rsp_dly idle cycles in MEM_WAIT before MemRspValid.
  task automatic run_txn(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int rdy_dly, input int rsp_dly, input bit berr);
    bit ok, tr;
    logic [31:0] e_data;
    bit e_err;
    ok = legal(wr, f3);
    tr = ok && TRAP && ((int'(addr[1:0]) % sz(f3)) != 0);
    chk("req_ready", {31'b0, ReqReady}, 32'd1);
    ReqValid = 1'b1; ReqWrite = wr; ReqFunct3 = f3; ReqAddr = addr; ReqWData = wd;
    tick();
    ReqValid = 1'b0; ReqAddr = $urandom; ReqWData = $urandom; ReqFunct3 = 3'($urandom);
    if (!ok || tr) begin
      chk("err_mrv", {31'b0, MemReqValid}, 32'd0);
      e_data = '0;
      e_err  = 1'b1;
    end else begin
      for (int i = 0; i <= rdy_dly; i++) begin
        chk("mrv",   {31'b0, MemReqValid}, 32'd1);
        chk("maddr", MemAddr, addr & 32'hFFFF_FFFC);
        chk("mbe",   {28'b0, MemBe}, {28'b0, exp_be(f3, addr)});
        chk("mwe",   {31'b0, MemWe}, {31'b0, wr});
        if (wr) chk("mwdata", MemWData, exp_wd(f3, wd));
        chk("req_rv", {31'b0, RspValid}, 32'd0);
        chk("busy",  {31'b0, Busy}, 32'd1);
        MemReqReady = (i == rdy_dly);
        tick();
      end
      MemReqReady = 1'b0;
      if (wr) begin
        e_data = '0;
        e_err  = 1'b0;
      end else begin
        for (int i = 0; i <= rsp_dly; i++) begin
          chk("wait_rv",  {31'b0, RspValid}, 32'd0);
          chk("wait_mrv", {31'b0, MemReqValid}, 32'd0);
          if (i == rsp_dly) begin
            MemRspValid = 1'b1; MemRData = rd; MemRspErr = berr;
          end else begin
            MemRData = $urandom; MemRspErr = 1'($urandom);
          end
          tick();
        end
        MemRspValid = 1'b0; MemRspErr = 1'b0; MemRData = $urandom;
        e_data = berr ? 32'h0 : exp_load(f3, addr, rd);
        e_err  = berr;
      end
    end
    chk("rsp_valid", {31'b0, RspValid}, 32'd1);
    chk("rsp_err",   {31'b0, RspErr}, {31'b0, e_err});
    chk("rsp_data",  RspData, e_data);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("misalign",  {31'b0, MisalignTrap}, {31'b0, tr});
`endif
    tick();
    chk("rsp_pulse", {31'b0, RspValid}, 32'd0);
    chk("idle_rdy",  {31'b0, ReqReady}, 32'd1);
    chk("idle_busy", {31'b0, Busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bit r_wr;
    logic [2:0] r_f3;
    reset = 1'b1; ReqValid = 0; ReqWrite = 0; ReqFunct3 = 0; ReqAddr = 0; ReqWData = 0;
    MemReqReady = 0; MemRspValid = 0; MemRData = 0; MemRspErr = 0;
    tick(); tick();
    // reset state
    chk("rst_ready", {31'b0, ReqReady}, 32'd1);
    chk("rst_busy",  {31'b0, Busy}, 32'd0);
    chk("rst_rv",    {31'b0, RspValid}, 32'd0);
    chk("rst_rdata", RspData, 32'd0);
    chk("rst_rerr",  {31'b0, RspErr}, 32'd0);
    chk("rst_mrv",   {31'b0, MemReqValid}, 32'd0);
    chk("rst_mbe",   {28'b0, MemBe}, 32'd0);
    chk("rst_maddr", MemAddr, 32'd0);
    chk("rst_mwd",   MemWData, 32'd0);
    reset = 1'b0;
    tick();

    // directed loads with literal expectations
    run_txn(0, 3'b000, 32'h103, 0, 32'h80FF_1234, 0, 0, 0);
    chk("lb_lit", exp_load(3'b000, 32'h103, 32'h80FF_1234), 32'hFFFF_FF80);
    run_txn(0, 3'b101, 32'h102, 0, 32'h8001_0000, 0, 0, 0);
    run_txn(0, 3'b001, 32'h102, 0, 32'h8001_0000, 0, 0, 0);
    // SB with ready held low 3 cycles
    run_txn(1, 3'b000, 32'h201, 32'h0000_00AB, 0, 3, 0, 0);
    // LW / SH at unaligned addresses
    run_txn(0, 3'b010, 32'h302, 0, 32'hDEAD_BEEF, 0, 0, 0);
    run_txn(1, 3'b001, 32'h305, 32'h1234_5678, 0, 0, 0, 0);
    run_txn(0, 3'b100, 32'h001, 0, 32'h0000_F700, 1, 2, 0);
    // illegal funct3 for load and store
    run_txn(0, 3'b011, 32'h40, 0, 0, 0, 0, 0);
    run_txn(1, 3'b100, 32'h40, 32'h55, 0, 0, 0, 0);
    // bus error on a load
    run_txn(0, 3'b010, 32'h500, 0, 32'h1111_2222, 0, 1, 1);
    // handshake in the last allowed cycle still wins over expiry
    run_txn(1, 3'b010, 32'h600, 32'hCAFE_F00D, 0, 7, 0, 0);

    // load timeout: handshake, then MemRspValid never asserted
    ReqValid = 1; ReqWrite = 0; ReqFunct3 = 3'b010; ReqAddr = 32'h700;
    tick(); ReqValid = 0;
    MemReqReady = 1; tick(); MemReqReady = 0;
    n = 2;
    while (!RspValid && n < 20) begin tick(); n++; end
    chk("to_ld_cycles", n, 32'd9);
    chk("to_ld_err",  {31'b0, RspErr}, 32'd1);
    chk("to_ld_data", RspData, 32'd0);
    tick();
    run_txn(0, 3'b000, 32'h702, 0, 32'h00AB_0000, 0, 0, 0);

    // store timeout: MemReqReady never asserted
    ReqValid = 1; ReqWrite = 1; ReqFunct3 = 3'b010; ReqAddr = 32'h800; ReqWData = 32'h1;
    tick(); ReqValid = 0;
    n = 1;
    while (!RspValid && n < 20) begin tick(); n++; end
    chk("to_st_cycles", n, 32'd9);
    chk("to_st_err",  {31'b0, RspErr}, 32'd1);
    chk("to_st_mrv",  {31'b0, MemReqValid}, 32'd0);
    tick();

    // reset in MEM_WAIT, then a late response
    ReqValid = 1; ReqWrite = 0; ReqFunct3 = 3'b010; ReqAddr = 32'h900;
    tick(); ReqValid = 0;
    MemReqReady = 1; tick(); MemReqReady = 0;
    chk("pre_rst_busy", {31'b0, Busy}, 32'd1);
    reset = 1; tick(); reset = 0;
    chk("mid_rst_ready", {31'b0, ReqReady}, 32'd1);
    chk("mid_rst_busy",  {31'b0, Busy}, 32'd0);
    MemRspValid = 1; MemRData = 32'h1234_5678; tick(); MemRspValid = 0;
    chk("late_rsp_rv",   {31'b0, RspValid}, 32'd0);
    chk("late_rsp_busy", {31'b0, Busy}, 32'd0);
    tick();
    chk("late_rsp_rv2",  {31'b0, RspValid}, 32'd0);
    chk("late_rsp_rdy",  {31'b0, ReqReady}, 32'd1);

    // randomized transactions (delays keep well inside the timeout)
    for (int k = 0; k < 40; k++) begin
      r_wr = 1'($urandom_range(0, 1));
      r_f3 = 3'($urandom_range(0, 7));
      run_txn(r_wr, r_f3, $urandom, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
